// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types, field indices and commands for the HD44780 bus driver
package lcd_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT} lcd_state_e;
  localparam int ON_BIT = 31;
  localparam int EN_BIT = 10;
  localparam int RS_BIT = 9;
  localparam int RW_BIT = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME = 8'h02;
  typedef struct packed {
    logic       rs;
    logic       rw;
    logic [7:0] data;
  } lcd_fields_t;
  function automatic logic is_long_cmd(input lcd_fields_t f);
    return !f.rs && (f.data == CMD_CLEAR || f.data == CMD_HOME);
  endfunction
  function automatic int max_of(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/lcd_delay_cnt.sv
// lcd_delay_cnt: loadable down counter, done on the last cycle of a loaded interval
// Ports: i_clk/i_rst_n clock and async active-low reset; i_load/i_load_val start an
// interval of i_load_val cycles; o_done is high in the final cycle of that interval.
module lcd_delay_cnt #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = i_load ? i_load_val : (cnt_q != '0 ? cnt_q - W'(1) : '0);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign o_done = cnt_q == W'(1);
endmodule

// File: rtl/lcd_bus_driver.sv
// lcd_bus_driver: turns o_io_lcd register requests into HD44780-timed LCD bus cycles
// Ports: i_clk, i_rst_n (async active low); i_io_lcd request word ([31] ON, [10] EN
// request, [9] RS, [8] RW, [7:0] DATA); o_lcd_data/rs/rw/en/on drive the LCD bus;
// o_busy flags an active or queued transaction; o_overflow is sticky on a dropped request.
module lcd_bus_driver
  import lcd_pkg::*;
#(
  parameter int T_AS_CYC   = 2,
  parameter int T_PW_CYC   = 23,
  parameter int T_H_CYC    = 1,
  parameter int T_EXEC_CYC = 2000,
  parameter int T_LONG_CYC = 82000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_io_lcd,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic        o_busy,
  output logic        o_overflow
);
  localparam int T_MAX = max_of(max_of(max_of(T_AS_CYC, T_PW_CYC), max_of(T_H_CYC, T_EXEC_CYC)), T_LONG_CYC);
  localparam int CW = $clog2(T_MAX + 1);
  lcd_state_e state_q, state_d;
  lcd_fields_t fields_q, fields_d, pend_q, pend_d, req;
  logic pend_v_q, pend_v_d, ovf_q, ovf_d, en_q, en_d, on_q, on_d, lcd_en_q, lcd_en_d;
  logic rise, take, cnt_load, cnt_done;
  logic [CW-1:0] cnt_val;
  logic unused_bits;
  assign unused_bits = ^i_io_lcd[30:11];
  assign req = '{rs: i_io_lcd[RS_BIT], rw: i_io_lcd[RW_BIT], data: i_io_lcd[DATA_MSB:DATA_LSB]};
  // en_q starts high so a request already asserted at reset release is not a rise
  assign rise = i_io_lcd[EN_BIT] & ~en_q;
  lcd_delay_cnt #(.W(CW)) u_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (cnt_load),
    .i_load_val (cnt_val),
    .o_done     (cnt_done)
  );
  always_comb begin
    state_d  = state_q;
    fields_d = fields_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    ovf_d    = ovf_q;
    en_d     = i_io_lcd[EN_BIT];
    on_d     = i_io_lcd[ON_BIT];
    cnt_load = 1'b0;
    cnt_val  = CW'(T_AS_CYC);
    take     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_v_q) take = 1'b1;
        else if (rise) begin
          state_d  = SETUP;
          fields_d = req;
          cnt_load = 1'b1;
        end
      end
      SETUP: if (cnt_done) begin
        state_d  = PULSE;
        cnt_load = 1'b1;
        cnt_val  = CW'(T_PW_CYC);
      end
      PULSE: if (cnt_done) begin
        state_d  = HOLD;
        cnt_load = 1'b1;
        cnt_val  = CW'(T_H_CYC);
      end
      HOLD: if (cnt_done) begin
        state_d  = WAIT;
        cnt_load = 1'b1;
        cnt_val  = is_long_cmd(fields_q) ? CW'(T_LONG_CYC) : CW'(T_EXEC_CYC);
      end
      WAIT: if (cnt_done) begin
        if (pend_v_q) take = 1'b1;
        else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      state_d  = SETUP;
      fields_d = pend_q;
      pend_v_d = 1'b0;
      cnt_load = 1'b1;
      cnt_val  = CW'(T_AS_CYC);
    end
    // a rise that cannot start immediately is queued in the single slot or dropped;
    // a full slot drops even when it is being consumed this very cycle
    if (rise && (state_q != IDLE || pend_v_q)) begin
      if (pend_v_q) ovf_d = 1'b1;
      else begin
        pend_d   = req;
        pend_v_d = 1'b1;
      end
    end
    lcd_en_d = state_d == PULSE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q  <= IDLE;
      fields_q <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      ovf_q    <= 1'b0;
      en_q     <= 1'b1;
      on_q     <= 1'b0;
      lcd_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fields_q <= fields_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      ovf_q    <= ovf_d;
      en_q     <= en_d;
      on_q     <= on_d;
      lcd_en_q <= lcd_en_d;
    end
  assign o_lcd_data = fields_q.data;
  assign o_lcd_rs   = fields_q.rs;
  assign o_lcd_rw   = fields_q.rw;
  assign o_lcd_en   = lcd_en_q;
  assign o_lcd_on   = on_q;
  assign o_busy     = (state_q != IDLE) | pend_v_q;
  assign o_overflow = ovf_q;
endmodule

// File: tb/tb_lcd_bus_driver.sv
// tb_lcd_bus_driver: self-checking bench with a transaction-timeline reference model
module tb_lcd_bus_driver;
  localparam int T_AS = 2, T_PW = 4, T_H = 1, T_EXEC = 10, T_LONG = 30;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [31:0] io = '0;
  logic [7:0] o_lcd_data;
  logic o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_busy, o_overflow;
  int checks = 0, errors = 0;
  lcd_bus_driver #(
    .T_AS_CYC(T_AS), .T_PW_CYC(T_PW), .T_H_CYC(T_H), .T_EXEC_CYC(T_EXEC), .T_LONG_CYC(T_LONG)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_io_lcd(io),
    .o_lcd_data(o_lcd_data), .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw),
    .o_lcd_en(o_lcd_en), .o_lcd_on(o_lcd_on), .o_busy(o_busy), .o_overflow(o_overflow)
  );
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end
  // model: each transaction is a start cycle plus a length; busy/EN are time windows
  int tcyc = 0, m_c = 0, m_end = 0;
  logic m_active, m_pend_v, m_ovf, m_prev_en, m_on;
  logic [9:0] m_cur, m_pend;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_active = 0; m_pend_v = 0; m_ovf = 0; m_prev_en = 1; m_on = 0; m_cur = '0; m_pend = '0;
  endtask
  task automatic model_start(input logic [9:0] f);
    m_cur = f;
    m_c = tcyc;
    m_end = tcyc + T_AS + T_PW + T_H + ((!f[9] && (f[7:0] == 8'h01 || f[7:0] == 8'h02)) ? T_LONG : T_EXEC);
    m_active = 1;
  endtask
  task automatic model_step(input logic [31:0] x);
    logic rise, act0, pv0;
    rise = x[10] && !m_prev_en;
    act0 = m_active;
    pv0 = m_pend_v;
    m_prev_en = x[10];
    m_on = x[31];
    if (m_active && tcyc == m_end) m_active = 0;
    if (!m_active && pv0) begin
      model_start(m_pend);
      m_pend_v = 0;
    end
    if (rise) begin
      if (!act0 && !pv0) model_start(x[9:0]);
      else if (pv0) m_ovf = 1;
      else begin
        m_pend = x[9:0];
        m_pend_v = 1;
      end
    end
    tcyc++;
  endtask
  function automatic logic [12:0] exp_vec();
    logic en;
    en = m_active && (tcyc - m_c > T_AS) && (tcyc - m_c <= T_AS + T_PW);
    return {m_on, m_ovf, m_active || m_pend_v, en, m_cur};
  endfunction
  function automatic logic [12:0] dut_vec();
    return {o_lcd_on, o_overflow, o_busy, o_lcd_en, o_lcd_rs, o_lcd_rw, o_lcd_data};
  endfunction
  task automatic step(input logic [31:0] x);
    io = x;
    model_step(x);
    @(posedge clk);
    #1;
    check("cycle_outputs", {19'd0, dut_vec()}, {19'd0, exp_vec()});
  endtask
  task automatic do_reset();
    rst_n = 0;
    #1;
    model_reset();
    check("async_reset_outputs", {19'd0, dut_vec()}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask
  // one request, optional extra rises (word w2) at loop indices r2/r3; counts busy/EN cycles
  task automatic run_txn(input logic [31:0] w, input logic [31:0] w2, input int r2, input int r3,
                         output int n, output int en_n, output int first, output int second);
    logic pe;
    n = 0; en_n = 0; first = -1; second = -1; pe = 0;
    step(w | 32'h400);
    while (o_busy && n < 300) begin
      if (o_lcd_en) begin
        en_n++;
        if (!pe) begin
          if (first < 0) first = n;
          else if (second < 0) second = n;
        end
      end
      pe = o_lcd_en;
      step((n == r2 || n == r3) ? (w2 | 32'h400) : (w & ~32'h400));
      n++;
    end
  endtask
  typedef struct {
    logic [31:0] w;
    int          busy;
    logic [9:0]  f;
  } vec_t;
  vec_t tbl[8];
  initial begin
    int n, en_n, first, second;
    logic [31:0] x;
    tbl[0] = '{32'h0000_0141, 17, 10'h141};
    tbl[1] = '{32'h0000_0341, 17, 10'h341};
    tbl[2] = '{32'h0000_0001, 37, 10'h001};
    tbl[3] = '{32'h0000_0002, 37, 10'h002};
    tbl[4] = '{32'h8000_0038, 17, 10'h038};
    tbl[5] = '{32'h0000_0201, 17, 10'h201};
    tbl[6] = '{32'h0000_0102, 37, 10'h102};
    tbl[7] = '{32'h0000_0003, 17, 10'h003};
    io = 32'h8000_0400;
    #2;
    do_reset();
    repeat (5) step(32'h8000_0400);
    check("held_en_ignored_busy", {31'd0, o_busy}, 32'd0);
    step(32'h8000_0000);
    run_txn(32'h8000_0541, 32'h0, -1, -1, n, en_n, first, second);
    check("held_then_raise_busy", n, 17);
    check("held_then_raise_en_start", first, T_AS);
    check("field_map_0x541", {22'd0, o_lcd_rs, o_lcd_rw, o_lcd_data}, 32'h141);
    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i].w, 32'h0, -1, -1, n, en_n, first, second);
      check("tbl_busy_cycles", n, tbl[i].busy);
      check("tbl_en_cycles", en_n, T_PW);
      check("tbl_en_start", first, T_AS);
      check("tbl_fields_hold", {22'd0, o_lcd_rs, o_lcd_rw, o_lcd_data}, {22'd0, tbl[i].f});
    end
    run_txn(32'h0000_0038, 32'h0000_0241, 3, -1, n, en_n, first, second);
    check("pend_busy_cycles", n, 34);
    check("pend_en_cycles", en_n, 2 * T_PW);
    check("pend_second_en_start", second, 17 + T_AS);
    check("pend_second_fields", {22'd0, o_lcd_rs, o_lcd_rw, o_lcd_data}, 32'h241);
    check("no_overflow_yet", {31'd0, o_overflow}, 32'd0);
    run_txn(32'h0000_0038, 32'h0000_0255, 1, 3, n, en_n, first, second);
    check("ovf_busy_cycles", n, 34);
    check("ovf_flag", {31'd0, o_overflow}, 32'd1);
    repeat (10) step(32'h0);
    check("ovf_sticky", {31'd0, o_overflow}, 32'd1);
    do_reset();
    check("ovf_cleared_by_reset", {31'd0, o_overflow}, 32'd0);
    step(32'h0000_0401);
    step(32'h0000_0001);
    step(32'h0000_0438);
    n = 0;
    while (!o_lcd_en && n < 50) begin
      step(32'h0);
      n++;
    end
    check("reached_pulse", {31'd0, o_lcd_en}, 32'd1);
    do_reset();
    check("reset_pulse_en", {31'd0, o_lcd_en}, 32'd0);
    check("reset_pulse_busy", {31'd0, o_busy}, 32'd0);
    repeat (40) step(32'h0);
    check("pending_discarded", {31'd0, o_busy}, 32'd0);
    for (int i = 0; i < 3000; i++) begin
      if (i % 600 == 599) do_reset();
      x = $urandom;
      x[10] = ($urandom_range(0, 15) == 0);
      x[9] = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: x[7:0] = 8'h01;
        1: x[7:0] = 8'h02;
        default: ;
      endcase
      step(x);
    end
    repeat (50) step(32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
